// File: rtl/sync_mul_pkg.sv
// rtl/sync_mul_pkg.sv - shared defaults and stage types for the sync multiplier arbiter
package sync_mul_pkg;

  localparam int DW_DEF    = 16;
  localparam int PW_DEF    = 32;
  localparam int N_REQ_MAX = 8;

  typedef logic [$clog2(N_REQ_MAX)-1:0] req_id_t;

  typedef struct packed {
    logic                     valid;
    req_id_t                  id;
    logic signed [DW_DEF-1:0] a;
    logic signed [DW_DEF-1:0] b;
  } op_stage_t;

  typedef struct packed {
    logic                     valid;
    req_id_t                  id;
    logic signed [PW_DEF-1:0] p;
  } stage_t;

endpackage

// File: rtl/sync_mul_pipe.sv
// rtl/sync_mul_pipe.sv - LAT-stage registered signed multiply pipeline with a ce gate
module sync_mul_pipe
  import sync_mul_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int PW  = PW_DEF,
  parameter int LAT = 2,
  parameter int IDW = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ce,
  input  logic                 in_valid,
  input  logic [IDW-1:0]       in_id,
  input  logic signed [DW-1:0] in_a,
  input  logic signed [DW-1:0] in_b,
  output logic                 out_valid,
  output logic [IDW-1:0]       out_id,
  output logic signed [PW-1:0] out_p,
  output logic                 busy
);

  typedef struct packed {
    logic                 valid;
    logic [IDW-1:0]       id;
    logic signed [DW-1:0] a;
    logic signed [DW-1:0] b;
  } op_t;

  typedef struct packed {
    logic                 valid;
    logic [IDW-1:0]       id;
    logic signed [PW-1:0] p;
  } prod_t;

  op_t                  s0;
  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] b_ext;
  logic signed [PW-1:0] prod;
  logic [LAT-1:0]       vld_vec;

  // Data fields only load with a valid beat so idle stages keep their contents
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0 <= '0;
    end else if (ce) begin
      s0.valid <= in_valid;
      if (in_valid) begin
        s0.id <= in_id;
        s0.a  <= in_a;
        s0.b  <= in_b;
      end
    end
  end

  assign a_ext = {{(PW-DW){s0.a[DW-1]}}, s0.a};
  assign b_ext = {{(PW-DW){s0.b[DW-1]}}, s0.b};
  assign prod  = a_ext * b_ext;
  assign vld_vec[0] = s0.valid;

  if (LAT == 1) begin : g_comb_out
    assign out_valid = s0.valid;
    assign out_id    = s0.id;
    assign out_p     = prod;
  end else begin : g_reg_out
    for (genvar s = 0; s < LAT-1; s++) begin : g_stage
      prod_t st;
      prod_t nxt;
      if (s == 0) begin : g_head
        assign nxt = {s0.valid, s0.id, prod};
      end else begin : g_tail
        assign nxt = g_stage[s-1].st;
      end
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          st <= '0;
        end else if (ce) begin
          st.valid <= nxt.valid;
          if (nxt.valid) begin
            st.id <= nxt.id;
            st.p  <= nxt.p;
          end
        end
      end
      assign vld_vec[s+1] = st.valid;
    end
    assign out_valid = g_stage[LAT-2].st.valid;
    assign out_id    = g_stage[LAT-2].st.id;
    assign out_p     = g_stage[LAT-2].st.p;
  end

  assign busy = |vld_vec;

endmodule

// File: rtl/sync_mul_arbiter.sv
// rtl/sync_mul_arbiter.sv - round-robin scheduler sharing one signed multiplier pipeline
module sync_mul_arbiter
  import sync_mul_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DW    = DW_DEF,
  parameter int PW    = PW_DEF,
  parameter int LAT   = 2
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic                     ce,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*DW-1:0]      req_a,
  input  logic [N_REQ*DW-1:0]      req_b,
  output logic                     res_valid,
  output logic [$clog2(N_REQ)-1:0] res_id,
  output logic [PW-1:0]            res_p,
  output logic                     busy
);

  localparam int IDW = $clog2(N_REQ);
  localparam logic [IDW:0] N_W = (IDW+1)'(N_REQ);

  logic [IDW-1:0]       rr_ptr;
  logic [IDW-1:0]       off;
  logic [IDW-1:0]       gnt_idx;
  logic [IDW-1:0]       ptr_nxt;
  logic [IDW:0]         sum;
  logic [IDW:0]         inc;
  logic [2*N_REQ-1:0]   dbl;
  logic [N_REQ-1:0]     rot;
  logic                 found;
  logic                 xfer;
  logic signed [DW-1:0] sel_a;
  logic signed [DW-1:0] sel_b;
  logic signed [PW-1:0] pipe_p;

  // Rotate so rr_ptr sits at bit 0, take the lowest set bit, then map back
  always_comb begin
    dbl   = {req_valid, req_valid} >> rr_ptr;
    rot   = dbl[N_REQ-1:0];
    found = 1'b0;
    off   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        off   = IDW'(k);
      end
    end
    sum = {1'b0, rr_ptr} + {1'b0, off};
    if (sum >= N_W) sum = sum - N_W;
    gnt_idx = sum[IDW-1:0];
  end

  assign xfer      = ce & found;
  assign req_ready = xfer ? (N_REQ'(1) << gnt_idx) : '0;
  assign inc       = {1'b0, gnt_idx} + (IDW+1)'(1);
  assign ptr_nxt   = (inc >= N_W) ? '0 : inc[IDW-1:0];

  always_comb begin
    sel_a = req_a[DW-1:0];
    sel_b = req_b[DW-1:0];
    for (int i = 0; i < N_REQ; i++) begin
      if (IDW'(i) == gnt_idx) begin
        sel_a = req_a[i*DW +: DW];
        sel_b = req_b[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      rr_ptr <= '0;
    end else if (xfer) begin
      rr_ptr <= ptr_nxt;
    end
  end

  sync_mul_pipe #(
    .DW  (DW),
    .PW  (PW),
    .LAT (LAT),
    .IDW (IDW)
  ) u_pipe (
    .clk       (ap_clk),
    .rst       (ap_rst),
    .ce        (ce),
    .in_valid  (xfer),
    .in_id     (gnt_idx),
    .in_a      (sel_a),
    .in_b      (sel_b),
    .out_valid (res_valid),
    .out_id    (res_id),
    .out_p     (pipe_p),
    .busy      (busy)
  );

  assign res_p = pipe_p;

endmodule
